// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the downstream ALU/register-file stage.
package instr_sequencer_pkg;

    localparam int unsigned INSTR_W  = 22;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned OP_W     = 2;

    // Instruction word: [21] halt, [20:19] opcode, [18:16] dest, [15:8] A, [7:0] B
    localparam int unsigned HALT_BIT = 21;
    localparam int unsigned OP_HI    = 20;
    localparam int unsigned OP_LO    = 19;
    localparam int unsigned DEST_HI  = 18;
    localparam int unsigned DEST_LO  = 16;
    localparam int unsigned A_HI     = 15;
    localparam int unsigned A_LO     = 8;
    localparam int unsigned B_HI     = 7;
    localparam int unsigned B_LO     = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program memory: synchronous write, combinational read, contents never reset.
module instr_mem
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps through a small program, issuing one ALU/register-file operation every three cycles.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               hold,
    output logic [OP_W-1:0]    opcode,
    output logic [DATA_W-1:0]  A,
    output logic [DATA_W-1:0]  B,
    output logic [REG_W-1:0]   write_reg,
    output logic               write_enable,
    output logic [REG_W-1:0]   read_reg,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      pc
);

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    state_t             r_state, w_state_nxt;
    logic [AW-1:0]      r_pc, w_pc_nxt;
    logic [INSTR_W-1:0] r_ir, w_ir_nxt;
    logic               r_we, w_we_nxt;
    logic [REG_W-1:0]   r_read_reg, w_read_reg_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [INSTR_W-1:0] w_mem_rdata;
    logic               w_mem_we;

    assign w_mem_we = prog_we && (r_state == ST_IDLE);

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_we       <= 1'b0;
            r_read_reg <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_we       <= w_we_nxt;
            r_read_reg <= w_read_reg_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_we_nxt       = 1'b0;
        w_read_reg_nxt = r_read_reg;
        if (hold) begin
            // Keep the pending write alive so it reappears once hold drops
            w_we_nxt = r_we;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_FETCH;
                        w_pc_nxt    = '0;
                    end
                end
                ST_FETCH: begin
                    w_ir_nxt    = w_mem_rdata;
                    w_state_nxt = ST_EXEC;
                end
                ST_EXEC: begin
                    w_we_nxt    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
                ST_WRITE: begin
                    w_read_reg_nxt = r_ir[DEST_HI:DEST_LO];
                    if (r_ir[HALT_BIT] || (r_pc == LAST_PC)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_pc_nxt    = r_pc + AW'(1);
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
        w_busy_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_EXEC) ||
                     (w_state_nxt == ST_WRITE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    assign opcode       = r_ir[OP_HI:OP_LO];
    assign A            = r_ir[A_HI:A_LO];
    assign B            = r_ir[B_HI:B_LO];
    assign write_reg    = r_ir[DEST_HI:DEST_LO];
    // hold suppresses the strobe within the same cycle
    assign write_enable = r_we & ~hold;
    assign read_reg     = r_read_reg;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pc           = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with hand-computed expectations.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [21:0] prog_data;
    logic        start;
    logic        hold;
    logic [1:0]  opcode;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  write_reg;
    logic        write_enable;
    logic [2:0]  read_reg;
    logic        busy;
    logic        done;
    logic [3:0]  pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_op   [16];
    logic [2:0] exp_dest [16];
    logic [7:0] exp_a    [16];
    logic [7:0] exp_b    [16];

    instr_sequencer #(.DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .start        (start),
        .hold         (hold),
        .opcode       (opcode),
        .A            (A),
        .B            (B),
        .write_reg    (write_reg),
        .write_enable (write_enable),
        .read_reg     (read_reg),
        .busy         (busy),
        .done         (done),
        .pc           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] mk(input logic halt, input logic [1:0] op,
                                       input logic [2:0] dest, input logic [7:0] a,
                                       input logic [7:0] b);
        return {halt, op, dest, a, b};
    endfunction

    task automatic load(input int addr, input logic [21:0] data);
        prog_we   = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 4; i++) begin
            exp_op[i]   = 2'(i);
            exp_dest[i] = 3'(i + 1);
            exp_a[i]    = 8'hAA;
            exp_b[i]    = 8'hCC;
            load(i, mk(i == 3, 2'(i), 3'(i + 1), 8'hAA, 8'hCC));
        end
    endtask

    // Runs a K-instruction program from start, checking every cycle against the 3-cycle schedule.
    task automatic run_prog(input int k, input int hold_n, input int hold_len,
                            input bit inj, input bit sw_en, input logic [21:0] sw_data);
        int eff;
        int held;
        int cyc;
        bit hnow;
        eff  = 0;
        held = 0;
        cyc  = 0;
        start = 1'b1;
        if (sw_en) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = sw_data;
        end
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        while (eff <= 3 * k + 1 && cyc < 400) begin
            hnow = (held < hold_len) && (eff == 3 * hold_n + 2);
            hold = hnow;
            if (inj && eff == 4) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd0;
                prog_data = 22'h3FFFFF;
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            #1;
            check("busy", busy, eff < 3 * k);
            check("done", done, eff == 3 * k);
            check("write_enable", write_enable, !hnow && (eff % 3 == 2) && (eff < 3 * k));
            if ((eff % 3 != 0) && (eff < 3 * k)) begin
                check("opcode", opcode, exp_op[eff / 3]);
                check("write_reg", write_reg, exp_dest[eff / 3]);
                check("A", A, exp_a[eff / 3]);
                check("B", B, exp_b[eff / 3]);
            end
            if (eff <= 3 * k) begin
                check("pc", pc, (eff < 3 * k) ? eff / 3 : k - 1);
            end
            if (eff == 3 * k) begin
                check("latency", cyc, 3 * k + hold_len);
                check("read_reg", read_reg, exp_dest[k - 1]);
            end
            tick();
            if (hnow) held++;
            else eff++;
            cyc++;
        end
        hold    = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
        if (cyc >= 400) check("timeout", 1, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", pc, 0);
        check("rst_opcode", opcode, 0);
        check("rst_we", write_enable, 0);
        rst_n = 1'b1;
        tick();

        // Basic 4-instruction program with halt on the last
        load_prog_a();
        run_prog(4, 0, 0, 1'b0, 1'b0, '0);

        // start/prog_we while busy are ignored; rerun proves memory untouched
        run_prog(4, 0, 0, 1'b1, 1'b0, '0);
        run_prog(4, 0, 0, 1'b0, 1'b0, '0);

        // Hold for 5 cycles during the write of instruction 1
        run_prog(4, 1, 5, 1'b0, 1'b0, '0);

        // Async reset during EXEC of instruction 2
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("pre_rst_opcode", opcode, 2);
        check("pre_rst_read_reg", read_reg, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_opcode", opcode, 0);
        check("arst_A", A, 0);
        check("arst_B", B, 0);
        check("arst_write_reg", write_reg, 0);
        check("arst_we", write_enable, 0);
        check("arst_read_reg", read_reg, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_pc", pc, 0);
        tick();
        check("arst_we_edge", write_enable, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_we", write_enable, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_read_reg", read_reg, 0);
        run_prog(4, 0, 0, 1'b0, 1'b0, '0);

        // Write to address 0 in the same cycle as start is seen by the first fetch
        exp_op[0]   = 2'd3;
        exp_dest[0] = 3'd5;
        exp_a[0]    = 8'h11;
        exp_b[0]    = 8'h22;
        run_prog(4, 0, 0, 1'b0, 1'b1, mk(1'b0, 2'd3, 3'd5, 8'h11, 8'h22));

        // Full memory without halt: runs 16 instructions and stops at pc 15
        for (int i = 0; i < 16; i++) begin
            exp_op[i]   = 2'(i % 4);
            exp_dest[i] = 3'(i % 8);
            exp_a[i]    = 8'(i);
            exp_b[i]    = 8'(255 - i);
            load(i, mk(1'b0, 2'(i % 4), 3'(i % 8), 8'(i), 8'(255 - i)));
        end
        run_prog(16, 0, 0, 1'b0, 1'b0, '0);
        tick();
        check("no_wrap_pc", pc, 15);
        check("no_wrap_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
